shared_mem_arbiter: RTL and testbench

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

---
 rtl/shared_mem_arbiter_pkg.sv | 18 +
 rtl/shared_mem_arbiter_smem_ram.sv | 23 ++
 rtl/shared_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared encodings for the shared-memory arbiter: FSM states, access ops, width defaults.
package shared_mem_arbiter_pkg;

    localparam int SMEM_ADDR_W = 12;
    localparam int SMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_e;

endpackage

// File: rtl/shared_mem_arbiter_smem_ram.sv
// Single-port shared memory, 2**ADDR_W x DATA_W, synchronous write and read, contents never reset.
module smem_ram
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = SMEM_ADDR_W,
    parameter int DATA_W = SMEM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbitrates per-core load/store requests onto one shared RAM, one transaction per 3 cycles.
// Define SMEM_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed lowest-index priority.
//
// Handshake: a core holds mem_req_ld/mem_req_st high (with address/data stable) until it sees
// its val_data bit pulse for one cycle; it must then drop both lines for at least one cycle
// before it can be granted again (the armed mask ignores levels still held after completion).
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = SMEM_ADDR_W,
    parameter int DATA_W    = SMEM_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        mem_req_ld,
    input  logic [NUM_CORES-1:0]        mem_req_st,
    input  logic [NUM_CORES*ADDR_W-1:0] addr_shared_memory,
    input  logic [NUM_CORES*DATA_W-1:0] mem_dat_st,
    output logic [NUM_CORES-1:0]        val_data,
    output logic [DATA_W-1:0]           mem_dat,
    output logic                        busy,
    output state_e                      dbg_state
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_e             state, state_n;
    logic [NUM_CORES-1:0] armed;
    logic [NUM_CORES-1:0] elig;
    logic                 any_elig;
    logic [IDX_W-1:0]     grant_n, grant_q;
    op_e                  op_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    ram_rdata;
    logic [DATA_W-1:0]    mem_dat_q;
    logic                 ram_we, ram_re;
    logic                 take;

    assign elig     = (mem_req_ld | mem_req_st) & armed;
    assign any_elig = |elig;
    assign take     = (state == IDLE) && any_elig;

`ifdef SMEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
    int               rr_idx;

    always_ff @(posedge clk) begin
        if (reset)     rr_ptr <= '0;
        else if (take) rr_ptr <= grant_n;
    end

    // Scan offsets high to low so the nearest eligible core above the pointer wins last.
    always_comb begin
        grant_n = '0;
        rr_idx  = 0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            rr_idx = int'(rr_ptr) + i;
            if (rr_idx >= NUM_CORES) rr_idx = rr_idx - NUM_CORES;
            if (elig[IDX_W'(rr_idx)]) grant_n = IDX_W'(rr_idx);
        end
    end
`else
    always_comb begin
        grant_n = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (elig[IDX_W'(i)]) grant_n = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_elig) state_n = ACCESS;
            ACCESS:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A simultaneous ld+st resolves to a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            op_q    <= OP_LD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            grant_q <= grant_n;
            op_q    <= mem_req_ld[grant_n] ? OP_LD : OP_ST;
            addr_q  <= addr_shared_memory[grant_n*ADDR_W +: ADDR_W];
            wdata_q <= mem_dat_st[grant_n*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= '1;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (state == RESP && grant_q == IDX_W'(k)) armed[k] <= 1'b0;
                else if (!mem_req_ld[k] && !mem_req_st[k]) armed[k] <= 1'b1;
            end
        end
    end

    // Reset gating keeps an aborted ACCESS from touching the RAM.
    assign ram_we = (state == ACCESS) && (op_q == OP_ST) && !reset;
    assign ram_re = (state == ACCESS) && (op_q == OP_LD) && !reset;

    smem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // mem_dat_q holds the last load result so stores leave the broadcast bus unchanged.
    always_ff @(posedge clk) begin
        if (reset)                                mem_dat_q <= '0;
        else if (state == RESP && op_q == OP_LD)  mem_dat_q <= ram_rdata;
    end

    assign mem_dat = (state == RESP && op_q == OP_LD) ? ram_rdata : mem_dat_q;

    always_comb begin
        val_data = '0;
        if (state == RESP) val_data[grant_q] = 1'b1;
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: drivers push expected {core, mem_dat} words, a monitor checks pulses.
module tb_shared_mem_arbiter;
    import shared_mem_arbiter_pkg::*;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     mem_req_ld;
    logic [NC-1:0]     mem_req_st;
    logic [NC*AW-1:0]  addr_shared_memory;
    logic [NC*DW-1:0]  mem_dat_st;
    logic [NC-1:0]     val_data;
    logic [DW-1:0]     mem_dat;
    logic              busy;
    state_e            dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [11:0] exp_q[$];
    int          pulse_q[$];
    int          mon_idx;
    logic [11:0] mon_got;

    shared_mem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_ld         (mem_req_ld),
        .mem_req_st         (mem_req_st),
        .addr_shared_memory (addr_shared_memory),
        .mem_dat_st         (mem_dat_st),
        .val_data           (val_data),
        .mem_dat            (mem_dat),
        .busy               (busy),
        .dbg_state          (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int core, input logic [7:0] data);
        exp_q.push_back({4'(core), data});
    endtask

    // Drive one request, wait for its pulse, then release (unless held) and leave one idle cycle.
    task automatic do_txn(input int core, input bit ld, input bit st, input logic [11:0] a,
                          input logic [7:0] d, input bit hold, input bit chk_lat);
        int  start;
        bit  seen;
        @(negedge clk);
        addr_shared_memory[core*AW +: AW] = a;
        mem_dat_st[core*DW +: DW]         = d;
        mem_req_ld[core]                  = ld;
        mem_req_st[core]                  = st;
        start = cyc;
        seen  = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (val_data[core]) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: core %0d got no val_data within 40 cycles, required a pulse", core);
        end else if (chk_lat) begin
            check("latency", 32'(cyc - start), 32'd2);
        end
        if (!hold) begin
            mem_req_ld[core] = 1'b0;
            mem_req_st[core] = 1'b0;
        end
        @(negedge clk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && val_data != '0) begin
            pulse_q.push_back(cyc);
            mon_idx = 0;
            for (int i = 0; i < NC; i++) if (val_data[i]) mon_idx = i;
            if (!$onehot(val_data)) begin
                n_cmp++;
                n_err++;
                $display("FAIL val_data_onehot: got 0x%0h, required exactly one bit", val_data);
            end
            mon_got = {4'(mon_idx), mem_dat};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: val_data=0x%0h mem_dat=0x%0h, required no pulse",
                         val_data, mem_dat);
            end else begin
                check("resp", 32'(mon_got), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        mem_req_ld         = '0;
        mem_req_st         = '0;
        addr_shared_memory = '0;
        mem_dat_st         = '0;
        apply_reset();
        @(negedge clk);
        check("rst_val_data", 32'(val_data), 32'd0);
        check("rst_mem_dat", 32'(mem_dat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // store then load back, same core
        push_exp(0, 8'h00); do_txn(0, 1'b0, 1'b1, 12'h123, 8'hA5, 1'b0, 1'b1);
        push_exp(0, 8'hA5); do_txn(0, 1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 1'b1);

        // ld+st together: load wins, memory untouched
        push_exp(2, 8'hA5); do_txn(2, 1'b0, 1'b1, 12'h010, 8'h3C, 1'b0, 1'b1);
        push_exp(3, 8'h3C); do_txn(3, 1'b1, 1'b1, 12'h010, 8'hFF, 1'b0, 1'b1);
        push_exp(0, 8'h3C); do_txn(0, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 1'b1);

        // reset during ACCESS of a store aborts it
        push_exp(1, 8'h3C); do_txn(1, 1'b0, 1'b1, 12'h200, 8'h11, 1'b0, 1'b1);
        @(negedge clk);
        addr_shared_memory[2*AW +: AW] = 12'h200;
        mem_dat_st[2*DW +: DW]         = 8'h77;
        mem_req_st[2]                  = 1'b1;
        @(negedge clk);
        check("abort_in_access", 32'(dbg_state), 32'(ACCESS));
        reset         = 1'b1;
        mem_req_st[2] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_mem_dat", 32'(mem_dat), 32'd0);
        repeat (3) @(negedge clk);
        push_exp(0, 8'h11); do_txn(0, 1'b1, 1'b0, 12'h200, 8'h00, 1'b0, 1'b1);

        // held store after completion is masked until it drops
        push_exp(1, 8'h11); do_txn(1, 1'b0, 1'b1, 12'h055, 8'h5A, 1'b1, 1'b1);
        mem_dat_st[1*DW +: DW] = 8'h99;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("held_masked_busy", 32'(busy), 32'd0);
        end
        mem_req_st[1] = 1'b0;
        @(negedge clk);
        push_exp(1, 8'h5A); do_txn(1, 1'b1, 1'b0, 12'h055, 8'h00, 1'b0, 1'b1);

        // address-space extremes and read-after-write
        push_exp(3, 8'h5A); do_txn(3, 1'b0, 1'b1, 12'hFFF, 8'hC3, 1'b0, 1'b1);
        push_exp(2, 8'hC3); do_txn(2, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b1);
        push_exp(1, 8'hC3); do_txn(1, 1'b0, 1'b1, 12'h000, 8'hE7, 1'b0, 1'b1);
        push_exp(1, 8'hE7); do_txn(1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1);

        // three simultaneous loads from a freshly reset pointer
        apply_reset();
        pulse_q.delete();
`ifdef SMEM_ARB_ROUND_ROBIN_EN
        push_exp(1, 8'h3C); push_exp(2, 8'h11); push_exp(0, 8'hA5);
`else
        push_exp(0, 8'hA5); push_exp(1, 8'h3C); push_exp(2, 8'h11);
`endif
        fork
            do_txn(0, 1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0);
            do_txn(1, 1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 1'b0);
            do_txn(2, 1'b1, 1'b0, 12'h200, 8'h00, 1'b0, 1'b0);
        join
        check("arb_pulse_count", 32'(pulse_q.size()), 32'd3);
        if (pulse_q.size() == 3) begin
            check("arb_gap_1", 32'(pulse_q[1] - pulse_q[0]), 32'd3);
            check("arb_gap_2", 32'(pulse_q[2] - pulse_q[1]), 32'd3);
        end

        repeat (5) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
